pong_game_ctrl: RTL

- Game-state and score producer for the Pong display path.
- Tracks the two-digit BCD score, balls remaining and game phase.
- Drives dig0/dig1/ball and the region-enable flags consumed by the text renderer and graphics blocks.
- Sits between paddle/ball collision logic (hit/miss pulses) and the text/graphics overlay mux.

---
 rtl/pong_pkg.sv | 37 +++
 rtl/bcd_counter2.sv | 32 +++
 rtl/pong_game_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-state controller.
package pong_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned SCORE_W          = 2 * BCD_W;
    localparam int unsigned BALL_W           = 2;
    localparam int unsigned TIMER_W          = 8;
    localparam int unsigned BALLS_INIT_DEF   = 3;
    localparam int unsigned TIMER_FRAMES_DEF = 120;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    // Two-digit BCD increment, {tens, ones}; 99 wraps to 00.
    function automatic logic [SCORE_W-1:0] bcd2_inc(input logic [SCORE_W-1:0] v);
        logic [BCD_W-1:0] d0;
        logic [BCD_W-1:0] d1;
        d0 = v[BCD_W-1:0];
        d1 = v[SCORE_W-1:BCD_W];
        if (d0 == BCD_W'(9)) begin
            d0 = '0;
            if (d1 == BCD_W'(9)) begin
                d1 = '0;
            end else begin
                d1 = d1 + BCD_W'(1);
            end
        end else begin
            d0 = d0 + BCD_W'(1);
        end
        return {d1, d0};
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear (priority) and increment.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] d0,
    output logic [BCD_W-1:0] d1
);

    logic [BCD_W-1:0] r_d0;
    logic [BCD_W-1:0] r_d1;

    // Count register: clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (clr) begin
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (inc) begin
            {r_d1, r_d0} <= bcd2_inc({r_d1, r_d0});
        end
    end

    assign d0 = r_d0;
    assign d1 = r_d1;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-state and score controller: phase FSM, BCD score, balls left,
// pause timer and region enables for the text/graphics overlay.
// Optional high-score tracking is built when PONG_HIGH_SCORE_EN is defined.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS_INIT   = BALLS_INIT_DEF,
    parameter int unsigned TIMER_FRAMES = TIMER_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn,
    input  logic             refr_tick,
    input  logic             hit,
    input  logic             miss,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1,
    output logic [BALL_W-1:0] ball,
    output logic             rule_en,
    output logic             over_en,
    output logic             play_en,
    output logic             serve,
    output logic [BCD_W-1:0] hi_dig0,
    output logic [BCD_W-1:0] hi_dig1
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_btn_q;
    logic                r_armed;
    logic                w_btn_rise;
    logic [TIMER_W-1:0]  r_timer;
    logic                w_timer_done;
    logic [BALL_W-1:0]   r_ball;
    logic                r_serve;
    logic                r_rule_en;
    logic                r_over_en;
    logic                r_play_en;
    logic                w_enter_play;
    logic                w_load_timer;
    logic                w_ball_dec;
    logic                w_ball_reload;
    logic                w_score_inc;
    logic                w_score_clr;
    logic [BCD_W-1:0]    w_dig0;
    logic [BCD_W-1:0]    w_dig1;

    // Button edge detect; a button already held when reset releases is not a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_btn_q <= btn;
            r_armed <= 1'b1;
        end
    end

    assign w_btn_rise   = btn & ~r_btn_q & r_armed;
    assign w_timer_done = (r_timer == '0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_NEWGAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-transition action decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_enter_play  = 1'b0;
        w_load_timer  = 1'b0;
        w_ball_dec    = 1'b0;
        w_ball_reload = 1'b0;
        w_score_inc   = 1'b0;
        w_score_clr   = 1'b0;
        case (r_state)
            ST_NEWGAME: begin
                if (w_btn_rise) begin
                    w_state_nxt  = ST_PLAY;
                    w_enter_play = 1'b1;
                    w_ball_dec   = 1'b1;
                end
            end
            ST_PLAY: begin
                w_score_inc = hit;
                if (miss) begin
                    w_load_timer = 1'b1;
                    w_state_nxt  = (r_ball == '0) ? ST_OVER : ST_NEWBALL;
                end
            end
            ST_NEWBALL: begin
                if (w_timer_done && w_btn_rise) begin
                    w_state_nxt  = ST_PLAY;
                    w_enter_play = 1'b1;
                    w_ball_dec   = 1'b1;
                end
            end
            ST_OVER: begin
                if (w_timer_done) begin
                    w_state_nxt   = ST_NEWGAME;
                    w_ball_reload = 1'b1;
                    w_score_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_NEWGAME;
            end
        endcase
    end

    // Pause timer: a load on the same cycle as a frame tick swallows the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_load_timer) begin
            r_timer <= TIMER_W'(TIMER_FRAMES - 1);
        end else if (refr_tick && !w_timer_done) begin
            r_timer <= r_timer - TIMER_W'(1);
        end
    end

    // Balls remaining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ball <= BALL_W'(BALLS_INIT);
        end else if (w_ball_reload) begin
            r_ball <= BALL_W'(BALLS_INIT);
        end else if (w_ball_dec) begin
            r_ball <= r_ball - BALL_W'(1);
        end
    end

    // Region enables and serve pulse, registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rule_en <= 1'b1;
            r_over_en <= 1'b0;
            r_play_en <= 1'b0;
            r_serve   <= 1'b0;
        end else begin
            r_rule_en <= (w_state_nxt == ST_NEWGAME);
            r_over_en <= (w_state_nxt == ST_OVER);
            r_play_en <= (w_state_nxt == ST_PLAY);
            r_serve   <= w_enter_play;
        end
    end

    bcd_counter2 u_score (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_score_inc),
        .clr     (w_score_clr),
        .d0      (w_dig0),
        .d1      (w_dig1)
    );

`ifdef PONG_HIGH_SCORE_EN
    logic [BCD_W-1:0]   r_hi_dig0;
    logic [BCD_W-1:0]   r_hi_dig1;
    logic [SCORE_W-1:0] w_score_final;
    logic               w_hi_latch;

    // Final score includes a hit that lands on the same cycle as the last miss.
    assign w_score_final = w_score_inc ? bcd2_inc({w_dig1, w_dig0}) : {w_dig1, w_dig0};
    assign w_hi_latch    = (r_state == ST_PLAY) && (w_state_nxt == ST_OVER);

    // High score: packed BCD compares correctly as binary, tens digit first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi_dig0 <= '0;
            r_hi_dig1 <= '0;
        end else if (w_hi_latch && (w_score_final > {r_hi_dig1, r_hi_dig0})) begin
            {r_hi_dig1, r_hi_dig0} <= w_score_final;
        end
    end

    assign hi_dig0 = r_hi_dig0;
    assign hi_dig1 = r_hi_dig1;
`else
    assign hi_dig0 = '0;
    assign hi_dig1 = '0;
`endif

    assign dig0    = w_dig0;
    assign dig1    = w_dig1;
    assign ball    = r_ball;
    assign rule_en = r_rule_en;
    assign over_en = r_over_en;
    assign play_en = r_play_en;
    assign serve   = r_serve;

endmodule
